// File: rtl/calc_key_pkg.sv
// Key-event encodings shared by the key encoder and the calculator/LCD block:
// event classes, operator indices, LCD character bytes and the one-hot decoders.
package calc_key_pkg;

  localparam logic [1:0] CLS_DIGIT = 2'd0;
  localparam logic [1:0] CLS_CLEAR = 2'd1;
  localparam logic [1:0] CLS_OP    = 2'd2;
  localparam logic [1:0] CLS_EQU   = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_REM  = 4'd4;
  localparam logic [3:0] OP_POW  = 4'd5;
  localparam logic [3:0] OP_FACT = 4'd6;

  localparam logic [7:0] CH_DIGIT0 = 8'h30;
  localparam logic [7:0] CH_BLANK  = 8'h20;
  localparam logic [7:0] CH_ADD    = 8'h2B;
  localparam logic [7:0] CH_SUB    = 8'h2D;
  localparam logic [7:0] CH_MUL    = 8'hD7;
  localparam logic [7:0] CH_DIV    = 8'h2F;
  localparam logic [7:0] CH_REM    = 8'hF7;
  localparam logic [7:0] CH_POW    = 8'h5E;
  localparam logic [7:0] CH_FACT   = 8'h21;
  localparam logic [7:0] CH_EQU    = 8'h3D;

  typedef struct packed {
    logic [1:0] cls;
    logic [3:0] code;
    logic [7:0] chr;
  } key_event_t;

  localparam key_event_t EV_IDLE = '{cls: CLS_DIGIT, code: 4'd0, chr: CH_BLANK};

  // Push switches: [11:2] carry digits 0..9 counting down from bit 11; [1:0] are clear.
  function automatic key_event_t decode_push(input logic [11:0] psh);
    key_event_t ev;
    ev = '{cls: CLS_CLEAR, code: 4'd0, chr: CH_BLANK};
    for (int i = 2; i < 12; i++) begin
      if (psh[i]) begin
        ev.cls  = CLS_DIGIT;
        ev.code = 4'(11 - i);
        ev.chr  = CH_DIGIT0 + 8'(11 - i);
      end
    end
    return ev;
  endfunction

  function automatic key_event_t decode_dip(input logic [7:0] dip);
    key_event_t ev;
    case (dip)
      8'h80:   ev = '{cls: CLS_OP, code: OP_ADD,  chr: CH_ADD};
      8'h40:   ev = '{cls: CLS_OP, code: OP_SUB,  chr: CH_SUB};
      8'h20:   ev = '{cls: CLS_OP, code: OP_MUL,  chr: CH_MUL};
      8'h10:   ev = '{cls: CLS_OP, code: OP_DIV,  chr: CH_DIV};
      8'h08:   ev = '{cls: CLS_OP, code: OP_REM,  chr: CH_REM};
      8'h04:   ev = '{cls: CLS_OP, code: OP_POW,  chr: CH_POW};
      8'h02:   ev = '{cls: CLS_OP, code: OP_FACT, chr: CH_FACT};
      default: ev = '{cls: CLS_EQU, code: 4'd0,   chr: CH_EQU};
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/calc_debounce.sv
// Width-W stable-sample debouncer: a new level is accepted once the sampled
// input has matched for DEB_TICKS consecutive ticks. level shows it in the accepting cycle.
module calc_debounce #(
  parameter int W         = 8,
  parameter int DEB_TICKS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic         change
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic [W-1:0]  last;
  logic [W-1:0]  level_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] run_len;

  // NOTE: every path assigns run_len; a path that left it unassigned would infer a latch.
  always_comb begin
    if (din != last)                 run_len = CW'(1);
    else if (cnt == CW'(DEB_TICKS))  run_len = cnt;
    else                             run_len = cnt + CW'(1);
  end

  assign change = tick && (run_len == CW'(DEB_TICKS)) && (din != level_q);
  assign level  = change ? din : level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last    <= '0;
      cnt     <= '0;
      level_q <= '0;
    end else if (tick) begin
      last    <= din;
      cnt     <= run_len;
      if (change) level_q <= din;
    end
  end

endmodule

// File: rtl/calc_key_event_encoder.sv
// Turns raw push/DIP switch levels into one debounced, decoded key event per
// press, delivered through a single-entry valid/ready register. DEB_TICKS >= 2.
import calc_key_pkg::*;

module calc_key_event_encoder #(
  parameter int TICK_DIV  = 50000,
  parameter int DEB_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw_psh,
  input  logic [7:0]  sw_dip,
  input  logic        ev_ready,
  output logic        ev_valid,
  output logic [1:0]  ev_class,
  output logic [3:0]  ev_code,
  output logic [7:0]  ev_char,
  output logic        ev_overflow,
  output logic        multi_key
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAND    = 2'd1;
  localparam logic [1:0] S_PRESSED = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [11:0]   psh_meta, psh_sync;
  logic [7:0]    dip_meta, dip_sync, dip_level;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    state;
  logic [11:0]   cand;
  logic [DW-1:0] cnt;
  logic          enter_pressed, push_raise, dip_change, dip_raise;
  logic          pend_valid;
  logic          slot_free, take_pend, take_push, take_dip, park_dip, drop;
  key_event_t    push_ev, dip_ev, pend_ev, load_ev, ev_q;

  // NOTE: non-blocking assignments keep the two synchroniser stages as separate flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psh_meta <= '0;
      psh_sync <= '0;
      dip_meta <= '0;
      dip_sync <= '0;
    end else begin
      psh_meta <= sw_psh;
      psh_sync <= psh_meta;
      dip_meta <= sw_dip;
      dip_sync <= dip_meta;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  assign enter_pressed = tick && (state == S_CAND) && (psh_sync == cand) &&
                         (cnt + DW'(1) == DW'(DEB_TICKS));
  assign push_raise    = enter_pressed && $onehot(cand);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cand      <= '0;
      cnt       <= '0;
      multi_key <= 1'b0;
    end else begin
      if (enter_pressed && !$onehot(cand)) multi_key <= 1'b1;
      if (tick) begin
        case (state)
          S_IDLE: if (psh_sync != '0) begin
            cand  <= psh_sync;
            cnt   <= DW'(1);
            state <= S_CAND;
          end
          S_CAND: begin
            if (psh_sync == '0)       state <= S_IDLE;
            else if (psh_sync != cand) begin
              cand <= psh_sync;
              cnt  <= DW'(1);
            end
            else if (enter_pressed)   state <= S_PRESSED;
            else                      cnt   <= cnt + DW'(1);
          end
          S_PRESSED: begin
            state <= S_RELEASE;
            cnt   <= '0;
          end
          S_RELEASE: begin
            if (psh_sync != '0) cnt <= '0;
            else if (cnt + DW'(1) == DW'(DEB_TICKS)) begin
              state <= S_IDLE;
              cnt   <= '0;
            end
            else cnt <= cnt + DW'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  calc_debounce #(.W(8), .DEB_TICKS(DEB_TICKS)) u_dip_deb (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .din    (dip_sync),
    .level  (dip_level),
    .change (dip_change)
  );

  assign dip_raise = dip_change && $onehot(dip_level);
  assign push_ev   = decode_push(cand);
  assign dip_ev    = decode_dip(dip_level);

  // A waiting DIP event is oldest, so it claims a free register before any new event.
  assign slot_free = !ev_valid || ev_ready;
  assign take_pend = slot_free && pend_valid;
  assign take_push = slot_free && !pend_valid && push_raise;
  assign take_dip  = slot_free && !pend_valid && !push_raise && dip_raise;
  assign park_dip  = dip_raise && push_raise && (!pend_valid || take_pend);
  assign drop      = (push_raise && !take_push) || (dip_raise && !take_dip && !park_dip);

  always_comb begin
    load_ev = dip_ev;
    if (take_pend)      load_ev = pend_ev;
    else if (take_push) load_ev = push_ev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid    <= 1'b0;
      ev_q        <= EV_IDLE;
      pend_valid  <= 1'b0;
      ev_overflow <= 1'b0;
    end else begin
      if (take_pend || take_push || take_dip) begin
        ev_valid <= 1'b1;
        ev_q     <= load_ev;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
      if (park_dip)       pend_valid <= 1'b1;
      else if (take_pend) pend_valid <= 1'b0;
      if (drop) ev_overflow <= 1'b1;
    end
  end

  // NOTE: pend_ev is payload qualified by pend_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (park_dip) pend_ev <= dip_ev;
  end

  assign ev_class = ev_q.cls;
  assign ev_code  = ev_q.code;
  assign ev_char  = ev_q.chr;

endmodule

// File: tb/tb_calc_key_event_encoder.sv
// Directed bench for calc_key_event_encoder: a tick-level behavioural model is
// compared every cycle, and hand-computed event lists pin each scenario.
module tb_calc_key_event_encoder;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam logic [7:0] OP_CHR [7] = '{8'h2B, 8'h2D, 8'hD7, 8'h2F, 8'hF7, 8'h5E, 8'h21};

  typedef struct packed {
    logic [1:0] cls;
    logic [3:0] code;
    logic [7:0] chr;
  } tb_ev_t;

  typedef struct {
    tb_ev_t ev;
    int     cyc;
  } seen_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ev_ready = 1'b1;
  logic [11:0] sw_psh = '0;
  logic [7:0]  sw_dip = '0;
  logic        ev_valid, ev_overflow, multi_key;
  logic [1:0]  ev_class;
  logic [3:0]  ev_code;
  logic [7:0]  ev_char;

  always #5 clk = ~clk;

  calc_key_event_encoder #(.TICK_DIV(TICK_DIV), .DEB_TICKS(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_psh      (sw_psh),
    .sw_dip      (sw_dip),
    .ev_ready    (ev_ready),
    .ev_valid    (ev_valid),
    .ev_class    (ev_class),
    .ev_code     (ev_code),
    .ev_char     (ev_char),
    .ev_overflow (ev_overflow),
    .multi_key   (multi_key)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  seen_t seen[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int low_bit(input logic [11:0] v);
    for (int i = 0; i < 12; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic tb_ev_t exp_push(input logic [11:0] v);
    tb_ev_t e;
    int     i;
    i = low_bit(v);
    if (i >= 2) begin
      e.cls  = 2'd0;
      e.code = 4'(11 - i);
      e.chr  = 8'(8'h30 + 11 - i);
    end else begin
      e.cls  = 2'd1;
      e.code = 4'd0;
      e.chr  = 8'h20;
    end
    return e;
  endfunction

  function automatic tb_ev_t exp_dip(input logic [7:0] v);
    tb_ev_t e;
    int     i;
    i = low_bit({4'b0, v});
    if (i == 0) begin
      e.cls  = 2'd3;
      e.code = 4'd0;
      e.chr  = 8'h3D;
    end else begin
      e.cls  = 2'd2;
      e.code = 4'(7 - i);
      e.chr  = OP_CHR[7 - i];
    end
    return e;
  endfunction

  // Behavioural model state, advanced once per clock edge
  int          m_phase, m_run_len, m_zeros;
  logic [11:0] m_p1, m_p2, m_run_val;
  logic [7:0]  m_d1, m_d2, m_snap;
  logic [7:0]  m_hist[$];
  bit          m_armed, m_skip, m_valid, m_pend, m_ovf, m_multi;
  tb_ev_t      m_ev, m_pend_ev;

  task automatic model_reset();
    m_phase = 0;  m_p1 = '0; m_p2 = '0; m_d1 = '0; m_d2 = '0;
    m_armed = 1;  m_skip = 0; m_run_len = 0; m_zeros = 0; m_run_val = '0;
    m_hist.delete(); m_snap = '0;
    m_valid = 0;  m_pend = 0; m_ovf = 0; m_multi = 0;
    m_ev = '{cls: 2'd0, code: 4'd0, chr: 8'h20};
    m_pend_ev = m_ev;
  endtask

  task automatic model_step();
    bit     tick, push_raise, dip_raise, slot_free, same;
    tb_ev_t pe, de;
    tick = (m_phase == TICK_DIV - 1);
    push_raise = 0;
    dip_raise  = 0;
    pe = m_ev;
    de = m_ev;
    m_phase = tick ? 0 : m_phase + 1;
    if (tick) begin
      if (m_armed) begin
        if (m_p2 == '0) m_run_len = 0;
        else if (m_run_len > 0 && m_p2 == m_run_val) m_run_len++;
        else begin
          m_run_val = m_p2;
          m_run_len = 1;
        end
        if (m_run_len == DEB) begin
          m_armed = 0;
          m_skip  = 1;
          m_zeros = 0;
          if ($countones(m_run_val) == 1) begin
            push_raise = 1;
            pe = exp_push(m_run_val);
          end else m_multi = 1;
        end
      end else if (m_skip) m_skip = 0;
      else begin
        m_zeros = (m_p2 == '0) ? m_zeros + 1 : 0;
        if (m_zeros == DEB) begin
          m_armed   = 1;
          m_run_len = 0;
        end
      end
      m_hist.push_back(m_d2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      same = (m_hist.size() == DEB);
      foreach (m_hist[k]) if (m_hist[k] != m_d2) same = 0;
      if (same && m_d2 != m_snap) begin
        m_snap = m_d2;
        if ($countones(m_d2) == 1) begin
          dip_raise = 1;
          de = exp_dip(m_d2);
        end
      end
    end
    slot_free = !m_valid || ev_ready;
    if (m_valid && ev_ready) m_valid = 0;
    if (m_pend && slot_free) begin
      m_ev = m_pend_ev; m_valid = 1; m_pend = 0; slot_free = 0;
    end
    if (push_raise) begin
      if (slot_free) begin
        m_ev = pe; m_valid = 1; slot_free = 0;
      end else m_ovf = 1;
    end
    if (dip_raise) begin
      if (slot_free) begin
        m_ev = de; m_valid = 1;
      end else if (push_raise && !m_pend) begin
        m_pend = 1; m_pend_ev = de;
      end else m_ovf = 1;
    end
    m_p2 = m_p1; m_p1 = sw_psh;
    m_d2 = m_d1; m_d1 = sw_dip;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // Per-cycle compare against the model, plus a log of consumed events
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("ev_valid", 32'(ev_valid), 32'(m_valid));
        if (m_valid) begin
          check("ev_class", 32'(ev_class), 32'(m_ev.cls));
          check("ev_code",  32'(ev_code),  32'(m_ev.code));
          check("ev_char",  32'(ev_char),  32'(m_ev.chr));
        end
        check("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
        check("multi_key",   32'(multi_key),   32'(m_multi));
        if (ev_valid && ev_ready)
          seen.push_back('{ev: '{cls: ev_class, code: ev_code, chr: ev_char}, cyc: cyc});
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
  endtask

  task automatic check_seen(input string name, input int idx, input tb_ev_t want);
    check({name, "_count"}, 32'(seen.size() > idx), 32'(1));
    if (idx < seen.size()) check(name, 32'(seen[idx].ev), 32'(want));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},    32'(ev_valid),    32'(0));
    check({tag, "_class"},    32'(ev_class),    32'(0));
    check({tag, "_code"},     32'(ev_code),     32'(0));
    check({tag, "_char"},     32'(ev_char),     32'(8'h20));
    check({tag, "_overflow"}, 32'(ev_overflow), 32'(0));
    check({tag, "_multi"},    32'(multi_key),   32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    ticks(2);

    // 1: digit 3 held, then released -> one event
    seen.delete();
    sw_psh = 12'h100; ticks(10);
    sw_psh = '0;      ticks(6);
    check("t1_events", 32'(seen.size()), 32'(1));
    check_seen("t1_ev", 0, '{cls: 2'd0, code: 4'd3, chr: 8'h33});

    // 2: bouncing digit 0 -> nothing
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      sw_psh = (i % 2 == 0) ? 12'h800 : 12'h000;
      ticks(1);
    end
    sw_psh = '0; ticks(6);
    check("t2_events", 32'(seen.size()), 32'(0));

    // 3: two keys together -> rejected, multi_key sticky
    seen.delete();
    sw_psh = 12'h0C0; ticks(5);
    sw_psh = '0;      ticks(6);
    #2;
    check("t3_events", 32'(seen.size()), 32'(0));
    check("t3_multi",  32'(multi_key),   32'(1));

    // 4: DIP multiply then equals
    seen.delete();
    sw_dip = 8'h20; ticks(5);
    sw_dip = 8'h01; ticks(5);
    check("t4_events", 32'(seen.size()), 32'(2));
    check_seen("t4_mul", 0, '{cls: 2'd2, code: 4'd2, chr: 8'hD7});
    check_seen("t4_equ", 1, '{cls: 2'd3, code: 4'd0, chr: 8'h3D});

    // 5: consumer stalled -> first event held, second dropped
    @(negedge clk);
    seen.delete();
    ev_ready = 1'b0;
    sw_psh = 12'h010; ticks(5);
    sw_psh = '0;      ticks(6);
    #2;
    check("t5_held_valid", 32'(ev_valid), 32'(1));
    check("t5_held_char",  32'(ev_char),  32'(8'h37));
    sw_psh = 12'h400; ticks(5);
    sw_psh = '0;      ticks(6);
    #2;
    check("t5_overflow",  32'(ev_overflow), 32'(1));
    check("t5_keep_char", 32'(ev_char),     32'(8'h37));
    @(negedge clk);
    ev_ready = 1'b1;
    ticks(2);
    check("t5_events", 32'(seen.size()), 32'(1));
    check_seen("t5_ev", 0, '{cls: 2'd0, code: 4'd7, chr: 8'h37});

    // 6: push and DIP on the same tick -> push first, DIP next cycle
    seen.delete();
    sw_psh = 12'h040; sw_dip = 8'h80; ticks(5);
    sw_psh = '0;      sw_dip = 8'h00; ticks(6);
    check("t6_events", 32'(seen.size()), 32'(2));
    check_seen("t6_digit", 0, '{cls: 2'd0, code: 4'd5, chr: 8'h35});
    check_seen("t6_plus",  1, '{cls: 2'd2, code: 4'd0, chr: 8'h2B});
    if (seen.size() == 2) check("t6_gap", 32'(seen[1].cyc - seen[0].cyc), 32'(1));

    // 6b: reset while digit 9 is held -> reset values, then exactly one event
    seen.delete();
    sw_psh = 12'h004; ticks(6);
    check_seen("t6b_pre", 0, '{cls: 2'd0, code: 4'd9, chr: 8'h39});
    rst = 1'b0;
    #1;
    check_reset_values("t6b_reset");
    repeat (3) @(negedge clk);
    seen.delete();
    rst = 1'b1;
    ticks(6);
    sw_psh = '0; ticks(6);
    check("t6b_events", 32'(seen.size()), 32'(1));
    check_seen("t6b_ev", 0, '{cls: 2'd0, code: 4'd9, chr: 8'h39});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
